// File: rtl/oddr_serializer_ctrl.sv
// ---------------------------------------------------------------------------
// oddr_serializer_ctrl
//
// Serialises WIDTH-bit words into bit pairs for a Gowin ODDR primitive.
// Words are taken over a valid/ready handshake. They pass through a one-entry
// hold register and then a shifter, which sends two bits per clk cycle on
// d0 (first half of the cycle) and d1 (second half of the cycle).
// After reset the block stays in a warm-up phase for WARMUP cycles. During
// that phase the pin is idle and in_ready is low, which lets the ODDR settle.
//
// Ports
//   clk        in   system clock, also drives the ODDR CLK pin
//   rst_n      in   asynchronous reset, active low
//   in_valid   in   in_data holds a valid word
//   in_ready   out  a word is accepted on this cycle's rising edge
//   in_data    in   WIDTH-bit word to serialise
//   d0         out  to ODDR D0
//   d1         out  to ODDR D1
//   tx         out  to ODDR TX (0 = driving data, 1 = idle/tristate)
//   busy       out  a word is waiting in the hold register or being shifted
//   frame_done out  high together with the last pair of each word
// ---------------------------------------------------------------------------
module oddr_serializer_ctrl #(
    parameter int   WIDTH     = 8,
    parameter int   WARMUP    = 4,
    parameter logic IDLE_LVL  = 1'b0,
    parameter bit   MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             d0,
    output logic             d1,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int PAIRS = WIDTH / 2;
    localparam int PCW   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int WCW   = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [PCW-1:0] LAST_PC   = PCW'(PAIRS - 1);
    localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP - 1);

    typedef enum logic {
        ST_WARM,
        ST_RUN
    } state_t;

    state_t           state_reg, state_next;
    logic [WCW-1:0]   warm_cnt_reg, warm_cnt_next;

    logic [WIDTH-1:0] hold_reg;
    logic             hold_valid_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             active_reg;
    logic [PCW-1:0]   pc_reg;
    logic             d0_reg, d1_reg, tx_reg, frame_done_reg;

    logic [WIDTH-1:0] hold_ord;
    logic [PCW-1:0]   pc_inc;
    logic             is_last;
    logic             take;
    logic             xfer;

    // The shifter always works MSB-first. For LSB-first output the held word
    // is bit-reversed on its way in, so the shift path stays the same for
    // both orders.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign hold_ord[gi] = hold_reg[gi];
            end else begin : g_lsb
                assign hold_ord[gi] = hold_reg[WIDTH-1-gi];
            end
        end
    endgenerate

    // ---------------- warm-up FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_WARM;
            warm_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            warm_cnt_reg <= warm_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        warm_cnt_next = warm_cnt_reg;
        case (state_reg)
            ST_WARM: begin
                if (warm_cnt_reg == WARM_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    warm_cnt_next = warm_cnt_reg + 1'b1;
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_WARM;
        endcase
    end

    // ---------------- handshake ----------------
    assign is_last  = (pc_reg == LAST_PC);
    assign pc_inc   = pc_reg + 1'b1;
    // The hold word moves to the shifter when the shifter is idle or is
    // sending its last pair. This frees the hold slot on the same edge.
    assign take     = hold_valid_reg & (~active_reg | is_last);
    assign in_ready = (state_reg == ST_RUN) & (~hold_valid_reg | take);
    assign xfer     = in_valid & in_ready;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            shift_reg      <= '0;
            active_reg     <= 1'b0;
            pc_reg         <= '0;
            d0_reg         <= IDLE_LVL;
            d1_reg         <= IDLE_LVL;
            tx_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            if (xfer) begin
                hold_reg       <= in_data;
                hold_valid_reg <= 1'b1;
            end else if (take) begin
                hold_valid_reg <= 1'b0;
            end

            if (take) begin
                // Pair 0 goes straight to the pins. The shifter keeps the
                // remaining pairs, aligned to its top bits.
                d0_reg         <= hold_ord[WIDTH-1];
                d1_reg         <= hold_ord[WIDTH-2];
                tx_reg         <= 1'b0;
                frame_done_reg <= (LAST_PC == '0);
                shift_reg      <= hold_ord << 2;
                pc_reg         <= '0;
                active_reg     <= 1'b1;
            end else if (active_reg && !is_last) begin
                d0_reg         <= shift_reg[WIDTH-1];
                d1_reg         <= shift_reg[WIDTH-2];
                tx_reg         <= 1'b0;
                frame_done_reg <= (pc_inc == LAST_PC);
                shift_reg      <= shift_reg << 2;
                pc_reg         <= pc_inc;
            end else begin
                d0_reg         <= IDLE_LVL;
                d1_reg         <= IDLE_LVL;
                tx_reg         <= 1'b1;
                frame_done_reg <= 1'b0;
                pc_reg         <= '0;
                active_reg     <= 1'b0;
            end
        end
    end

    assign d0         = d0_reg;
    assign d1         = d1_reg;
    assign tx         = tx_reg;
    assign frame_done = frame_done_reg;
    assign busy       = hold_valid_reg | active_reg;

endmodule
